fetch_queue: RTL and testbench

//  Decoupling FIFO between instruction fetch and decode. Each cycle it captures the PC chosen by
//  PC select, the fetched instruction word and the redirect/prediction tag, then presents them in

---
 rtl/fetch_queue_if.sv | 32 +++
 rtl/fetch_queue.sv | 75 +++++++
 tb/tb_fetch_queue.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: fetch slot in, decode head out, plus backpressure status.
interface fetch_queue_if #(
    parameter int WIDTH = 31,
    parameter int PTRW  = 2
);
    logic             fetchValid;
    logic [WIDTH:0]   fetchPC;
    logic [WIDTH:0]   fetchInstr;
    logic             fetchRedirect;
    logic [WIDTH:0]   fetchPredPC;
    logic             decodeReady;
    logic             decodeValid;
    logic [WIDTH:0]   decodePC;
    logic [WIDTH:0]   decodeInstr;
    logic             decodeRedirect;
    logic [WIDTH:0]   decodePredPC;
    logic             queueFull;
    logic             almostFull;
    logic [PTRW:0]    count;

    modport master (
        output fetchValid, fetchPC, fetchInstr, fetchRedirect, fetchPredPC, decodeReady,
        input  decodeValid, decodePC, decodeInstr, decodeRedirect, decodePredPC,
               queueFull, almostFull, count
    );

    modport slave (
        input  fetchValid, fetchPC, fetchInstr, fetchRedirect, fetchPredPC, decodeReady,
        output decodeValid, decodePC, decodeInstr, decodeRedirect, decodePredPC,
               queueFull, almostFull, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular-buffer FIFO decoupling fetch from decode; emptied by commit-stage flush.
module fetch_queue #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input logic          clk,
    input logic          globalReset,
    input logic          flush,
    fetch_queue_if.slave bus
);
    typedef struct packed {
        logic [WIDTH:0] pc;
        logic [WIDTH:0] instr;
        logic           redirect;
        logic [WIDTH:0] predPC;
    } entryT;

    localparam logic [PTRW:0] FullCount = (PTRW+1)'(DEPTH);

    entryT           mem [DEPTH];
    entryT           head;
    logic [PTRW-1:0] rdPtr;
    logic [PTRW-1:0] wrPtr;
    logic [PTRW:0]   cnt;
    logic            isFull;
    logic            isEmpty;
    logic            push;
    logic            pop;

    // Status is derived from the registered count only, never from this cycle's handshakes.
    always_comb begin
        isFull  = (cnt == FullCount);
        isEmpty = (cnt == '0);
        push    = bus.fetchValid & ~isFull & ~flush;
        pop     = bus.decodeReady & ~isEmpty & ~flush;
        head    = isEmpty ? '0 : mem[rdPtr];
    end

    always_comb begin
        bus.decodeValid    = ~isEmpty;
        bus.decodePC       = head.pc;
        bus.decodeInstr    = head.instr;
        bus.decodeRedirect = head.redirect;
        bus.decodePredPC   = head.predPC;
        bus.queueFull      = isFull;
        bus.almostFull     = (cnt >= FullCount - 1'b1);
        bus.count          = cnt;
    end

    always_ff @(posedge clk) begin
        if (globalReset || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= '{pc:       bus.fetchPC,
                            instr:    bus.fetchInstr,
                            redirect: bus.fetchRedirect,
                            predPC:   bus.fetchPredPC};
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed vector bench for fetch_queue (DEPTH=4): cycle table plus hand-written corner sequences.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst;
    logic fl;
    int   nVec = 0;
    int   nErr = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.WIDTH(31), .PTRW(2)) bus ();

    fetch_queue #(.WIDTH(31), .DEPTH(4), .PTRW(2)) dut (
        .clk        (clk),
        .globalReset(rst),
        .flush      (fl),
        .bus        (bus)
    );

    typedef struct {
        bit          r, f, fv, rd, dr;
        logic [31:0] pc, ins, pp;
        bit          ev, erd;
        logic [31:0] epc, eins, epp;
        int          ecnt;
    } vecT;

    vecT vq[$];

    task automatic add(input bit r, input bit f, input bit fv, input logic [31:0] pc,
                       input logic [31:0] ins, input bit rd, input logic [31:0] pp, input bit dr,
                       input bit ev, input logic [31:0] epc, input logic [31:0] eins,
                       input bit erd, input logic [31:0] epp, input int ecnt);
        vecT v;
        v.r = r; v.f = f; v.fv = fv; v.pc = pc; v.ins = ins; v.rd = rd; v.pp = pp; v.dr = dr;
        v.ev = ev; v.epc = epc; v.eins = eins; v.erd = erd; v.epp = epp; v.ecnt = ecnt;
        vq.push_back(v);
    endtask

    task automatic drive(input bit r, input bit f, input bit fv, input logic [31:0] pc,
                         input logic [31:0] ins, input bit rd, input logic [31:0] pp, input bit dr);
        rst               = r;
        fl                = f;
        bus.fetchValid    = fv;
        bus.fetchPC       = pc;
        bus.fetchInstr    = ins;
        bus.fetchRedirect = rd;
        bus.fetchPredPC   = pp;
        bus.decodeReady   = dr;
    endtask

    task automatic check(input int id, input bit ev, input logic [31:0] epc,
                         input logic [31:0] eins, input bit erd, input logic [31:0] epp,
                         input int ecnt);
        bit eFull;
        bit eAfull;
        eFull  = (ecnt == 4);
        eAfull = (ecnt >= 3);
        nVec++;
        if (bus.decodeValid !== ev || bus.decodePC !== epc || bus.decodeInstr !== eins ||
            bus.decodeRedirect !== erd || bus.decodePredPC !== epp ||
            int'(bus.count) != ecnt || bus.queueFull !== eFull || bus.almostFull !== eAfull) begin
            nErr++;
            $display("FAIL vec%0d got v=%0b pc=%0d ins=%0h rd=%0b pp=%0d cnt=%0d full=%0b af=%0b want v=%0b pc=%0d ins=%0h rd=%0b pp=%0d cnt=%0d full=%0b af=%0b",
                     id, bus.decodeValid, bus.decodePC, bus.decodeInstr, bus.decodeRedirect,
                     bus.decodePredPC, bus.count, bus.queueFull, bus.almostFull,
                     ev, epc, eins, erd, epp, ecnt, eFull, eAfull);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        //  r f fv pc  ins   rd pp dr | ev epc eins erd epp cnt
        add(1,0,0, 0,  0,    0,0, 0,   0, 0,  0,    0,0,  0);
        add(0,0,1, 20,'hA0,  0,0, 0,   1, 20,'hA0,  0,0,  1);
        add(0,0,1, 21,'hA1,  0,0, 0,   1, 20,'hA0,  0,0,  2);
        add(0,0,1, 22,'hA2,  0,0, 0,   1, 20,'hA0,  0,0,  3);
        add(0,0,0, 0,  0,    0,0, 1,   1, 21,'hA1,  0,0,  2);
        add(0,0,0, 0,  0,    0,0, 1,   1, 22,'hA2,  0,0,  1);
        add(0,0,0, 0,  0,    0,0, 1,   0, 0,  0,    0,0,  0);
        add(0,0,0, 0,  0,    0,0, 1,   0, 0,  0,    0,0,  0);
        // fill to full, overflow dropped (also with a same-cycle pop), then drain
        add(0,0,1, 50,'hB0,  0,0, 0,   1, 50,'hB0,  0,0,  1);
        add(0,0,1, 51,'hB1,  0,0, 0,   1, 50,'hB0,  0,0,  2);
        add(0,0,1, 52,'hB2,  0,0, 0,   1, 50,'hB0,  0,0,  3);
        add(0,0,1, 53,'hB3,  0,0, 0,   1, 50,'hB0,  0,0,  4);
        add(0,0,1, 54,'hB4,  0,0, 0,   1, 50,'hB0,  0,0,  4);
        add(0,0,1, 55,'hB5,  0,0, 1,   1, 51,'hB1,  0,0,  3);
        add(0,0,0, 0,  0,    0,0, 1,   1, 52,'hB2,  0,0,  2);
        add(0,0,0, 0,  0,    0,0, 1,   1, 53,'hB3,  0,0,  1);
        add(0,0,0, 0,  0,    0,0, 1,   0, 0,  0,    0,0,  0);
        // concurrent push+pop at count 2 across pointer wrap, with a redirect tag
        add(0,0,1, 60,'hC0,  0,0, 0,   1, 60,'hC0,  0,0,  1);
        add(0,0,1, 61,'hC1,  0,0, 0,   1, 60,'hC0,  0,0,  2);
        add(0,0,1, 30,'hC2,  1,70,1,   1, 61,'hC1,  0,0,  2);
        add(0,0,1, 31,'hC3,  0,0, 1,   1, 30,'hC2,  1,70, 2);
        add(0,0,1, 32,'hC4,  0,0, 1,   1, 31,'hC3,  0,0,  2);
        add(0,0,1, 33,'hC5,  0,0, 1,   1, 32,'hC4,  0,0,  2);
        add(0,0,1, 34,'hC6,  0,0, 1,   1, 33,'hC5,  0,0,  2);
        add(0,0,1, 35,'hC7,  0,0, 1,   1, 34,'hC6,  0,0,  2);
        add(0,0,0, 0,  0,    0,0, 1,   1, 35,'hC7,  0,0,  1);
        add(0,0,0, 0,  0,    0,0, 1,   0, 0,  0,    0,0,  0);
        // flush with push and pop pending, then reset/flush mid-stream
        add(0,0,1, 80,'hD0,  0,0, 0,   1, 80,'hD0,  0,0,  1);
        add(0,0,1, 81,'hD1,  0,0, 0,   1, 80,'hD0,  0,0,  2);
        add(0,0,1, 82,'hD2,  0,0, 0,   1, 80,'hD0,  0,0,  3);
        add(0,1,1, 99,'hEE,  0,0, 1,   0, 0,  0,    0,0,  0);
        add(0,0,1, 50,'hD5,  0,0, 0,   1, 50,'hD5,  0,0,  1);
        add(0,0,1, 51,'hD6,  0,0, 0,   1, 50,'hD5,  0,0,  2);
        add(1,1,1, 77,'hEF,  0,0, 1,   0, 0,  0,    0,0,  0);
        add(0,0,1, 90,'hF0,  0,0, 0,   1, 90,'hF0,  0,0,  1);
        add(1,0,1, 91,'hF1,  0,0, 0,   0, 0,  0,    0,0,  0);
        add(0,0,1, 92,'hF2,  0,0, 0,   1, 92,'hF2,  0,0,  1);
        add(0,1,0, 0,  0,    0,0, 1,   0, 0,  0,    0,0,  0);

        foreach (vq[i]) begin
            drive(vq[i].r, vq[i].f, vq[i].fv, vq[i].pc, vq[i].ins, vq[i].rd, vq[i].pp, vq[i].dr);
            @(posedge clk);
            #1;
            check(i, vq[i].ev, vq[i].epc, vq[i].eins, vq[i].erd, vq[i].epp, vq[i].ecnt);
        end

        // No same-cycle bypass: a pending push into an empty queue is not visible before the edge.
        drive(0, 0, 1, 40, 'hE0, 0, 0, 1);
        #1;
        check(100, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check(101, 1, 40, 'hE0, 0, 0, 1);
        drive(0, 0, 1, 41, 'hE1, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 1, 42, 'hE2, 0, 0, 0);
        @(posedge clk); #1;
        check(102, 1, 40, 'hE0, 0, 0, 3);

        // Status outputs must not react combinationally to a pending push or pop.
        drive(0, 0, 1, 43, 'hE3, 0, 0, 0);
        #2;
        check(103, 1, 40, 'hE0, 0, 0, 3);
        @(posedge clk); #1;
        check(104, 1, 40, 'hE0, 0, 0, 4);
        drive(0, 0, 1, 44, 'hE4, 0, 0, 1);
        #2;
        check(105, 1, 40, 'hE0, 0, 0, 4);
        @(posedge clk); #1;
        check(106, 1, 41, 'hE1, 0, 0, 3);

        drive(0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        check(107, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
